// File: rtl/cmd_frame_pkg.sv
// Shared constants for the command frame decoder: command codes, FSM encoding,
// and the fixed register addresses used for ALU operands.
package cmd_frame_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int ALU_A_ADDR = 0;
  localparam int ALU_B_ADDR = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_ALU_A,
    S_ALU_B,
    S_ALU_FUN
  } state_t;

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Inter-byte idle counter: flags expiry after TIMEOUT_CYCLES enabled cycles
// with no restart. Only instantiated when CMD_FRAME_TIMEOUT_EN is defined.
module cmd_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // The Nth idle cycle sees cnt == N-1, so expiry lands on the TIMEOUT_CYCLES-th one.
  assign expired = enable && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                    cnt <= '0;
    else if (restart || !enable) cnt <= '0;
    else if (!expired)          cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/cmd_frame_decoder.sv
// Assembles synchronized RX bytes into WR/RD/ALU command frames and issues
// registered one-cycle strobes. Optional idle abort: CMD_FRAME_TIMEOUT_EN.
module cmd_frame_decoder
  import cmd_frame_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  alu_en,
  output logic [FUN_WIDTH-1:0]  alu_fun,
  output logic                  frame_err,
  output logic                  busy
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("cmd_frame_decoder: TIMEOUT_CYCLES must be >= 2");
  end

  state_t                state, nxt_state;
  logic [ADDR_WIDTH-1:0] addr_q, nxt_addr_q;
  logic                  nxt_wr_en, nxt_rd_en, nxt_alu_en, nxt_err;
  logic [ADDR_WIDTH-1:0] nxt_reg_addr;
  logic [DATA_WIDTH-1:0] nxt_wr_data;
  logic [FUN_WIDTH-1:0]  nxt_alu_fun;
  logic                  timeout_hit;

  assign busy = (state != S_IDLE);

`ifdef CMD_FRAME_TIMEOUT_EN
  cmd_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .restart (rx_valid),
    .enable  (busy),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      addr_q <= '0;
    end else begin
      state  <= nxt_state;
      addr_q <= nxt_addr_q;
    end
  end

  always_comb begin
    nxt_state    = state;
    nxt_addr_q   = addr_q;
    nxt_wr_en    = 1'b0;
    nxt_rd_en    = 1'b0;
    nxt_alu_en   = 1'b0;
    nxt_err      = 1'b0;
    nxt_reg_addr = reg_addr;
    nxt_wr_data  = reg_wr_data;
    nxt_alu_fun  = alu_fun;
    // A byte arriving on the terminal count is accepted; abort only on a truly idle cycle.
    if (timeout_hit && !rx_valid) begin
      nxt_state = S_IDLE;
      nxt_err   = 1'b1;
    end else if (rx_valid) begin
      case (state)
        S_IDLE: begin
          if      (rx_data == DATA_WIDTH'(CMD_WR))      nxt_state = S_WR_ADDR;
          else if (rx_data == DATA_WIDTH'(CMD_RD))      nxt_state = S_RD_ADDR;
          else if (rx_data == DATA_WIDTH'(CMD_ALU_OP))  nxt_state = S_ALU_A;
          else if (rx_data == DATA_WIDTH'(CMD_ALU_NOP)) nxt_state = S_ALU_FUN;
          else                                          nxt_err   = 1'b1;
        end
        S_WR_ADDR: begin
          nxt_addr_q = rx_data[ADDR_WIDTH-1:0];
          nxt_state  = S_WR_DATA;
        end
        S_WR_DATA: begin
          nxt_wr_en    = 1'b1;
          nxt_reg_addr = addr_q;
          nxt_wr_data  = rx_data;
          nxt_state    = S_IDLE;
        end
        S_RD_ADDR: begin
          nxt_rd_en    = 1'b1;
          nxt_reg_addr = rx_data[ADDR_WIDTH-1:0];
          nxt_state    = S_IDLE;
        end
        S_ALU_A: begin
          nxt_wr_en    = 1'b1;
          nxt_reg_addr = ADDR_WIDTH'(ALU_A_ADDR);
          nxt_wr_data  = rx_data;
          nxt_state    = S_ALU_B;
        end
        S_ALU_B: begin
          nxt_wr_en    = 1'b1;
          nxt_reg_addr = ADDR_WIDTH'(ALU_B_ADDR);
          nxt_wr_data  = rx_data;
          nxt_state    = S_ALU_FUN;
        end
        S_ALU_FUN: begin
          nxt_alu_en  = 1'b1;
          nxt_alu_fun = rx_data[FUN_WIDTH-1:0];
          nxt_state   = S_IDLE;
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      alu_en      <= 1'b0;
      frame_err   <= 1'b0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      alu_fun     <= '0;
    end else begin
      reg_wr_en   <= nxt_wr_en;
      reg_rd_en   <= nxt_rd_en;
      alu_en      <= nxt_alu_en;
      frame_err   <= nxt_err;
      reg_addr    <= nxt_reg_addr;
      reg_wr_data <= nxt_wr_data;
      alu_fun     <= nxt_alu_fun;
    end
  end

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed bench for cmd_frame_decoder; the timeout scenario runs only when
// CMD_FRAME_TIMEOUT_EN is defined (TIMEOUT_CYCLES forced to 16).
module tb_cmd_frame_decoder;

`ifdef CMD_FRAME_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       reg_wr_en, reg_rd_en, alu_en, frame_err, busy;
  logic [3:0] reg_addr, alu_fun;
  logic [7:0] reg_wr_data;

  int checks = 0, passed = 0;
  int wr_cnt, rd_cnt, alu_cnt, err_cnt;

  cmd_frame_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .alu_en(alu_en), .alu_fun(alu_fun),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Drive at a negedge, advance one cycle, then tally the strobes seen.
  task automatic tick(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(negedge CLK);
    if (reg_wr_en) wr_cnt++;
    if (reg_rd_en) rd_cnt++;
    if (alu_en)    alu_cnt++;
    if (frame_err) err_cnt++;
  endtask

  task automatic clr();
    wr_cnt = 0; rd_cnt = 0; alu_cnt = 0; err_cnt = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(1'b1, 8'hAA);
    checks++;
    if ({reg_wr_en, reg_rd_en, alu_en, frame_err, busy, reg_addr, reg_wr_data, alu_fun} !== 25'd0)
      $display("FAIL reset_outputs: got wr=%b rd=%b alu=%b err=%b busy=%b addr=%h data=%h fun=%h, want all 0",
               reg_wr_en, reg_rd_en, alu_en, frame_err, busy, reg_addr, reg_wr_data, alu_fun);
    else passed++;
    RST = 1'b0;
    tick(1'b0, 8'h00);
  endtask

  task automatic test_write();
    clr();
    tick(1'b1, 8'hAA);
    checks++;
    if (busy !== 1'b1) $display("FAIL wr_busy_mid: got %b want 1", busy); else passed++;
    tick(1'b1, 8'h05);
    tick(1'b1, 8'h3C);
    checks++;
    if ({reg_wr_en, reg_addr, reg_wr_data} !== {1'b1, 4'h5, 8'h3C})
      $display("FAIL wr_strobe: got en=%b addr=%h data=%h want en=1 addr=5 data=3c",
               reg_wr_en, reg_addr, reg_wr_data);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL wr_busy_after: got %b want 0", busy); else passed++;
    tick(1'b0, 8'h00);
    checks++;
    if ({wr_cnt, rd_cnt, alu_cnt, err_cnt} !== {32'd1, 32'd0, 32'd0, 32'd0})
      $display("FAIL wr_counts: got wr=%0d rd=%0d alu=%0d err=%0d want 1/0/0/0", wr_cnt, rd_cnt, alu_cnt, err_cnt);
    else passed++;
  endtask

  task automatic test_read();
    clr();
    tick(1'b1, 8'hBB);
    tick(1'b1, 8'h0A);
    checks++;
    if ({reg_rd_en, reg_addr} !== {1'b1, 4'hA})
      $display("FAIL rd_strobe: got en=%b addr=%h want en=1 addr=a", reg_rd_en, reg_addr);
    else passed++;
    tick(1'b0, 8'h00);
    checks++;
    if ({wr_cnt, rd_cnt, alu_cnt} !== {32'd0, 32'd1, 32'd0})
      $display("FAIL rd_counts: got wr=%0d rd=%0d alu=%0d want 0/1/0", wr_cnt, rd_cnt, alu_cnt);
    else passed++;
    checks++;
    if (reg_wr_data !== 8'h3C) $display("FAIL rd_hold_wdata: got %h want 3c", reg_wr_data); else passed++;
  endtask

  task automatic test_alu_op();
    clr();
    tick(1'b1, 8'hCC);
    tick(1'b1, 8'h12);
    checks++;
    if ({reg_wr_en, reg_addr, reg_wr_data} !== {1'b1, 4'h0, 8'h12})
      $display("FAIL alu_wr_a: got en=%b addr=%h data=%h want en=1 addr=0 data=12", reg_wr_en, reg_addr, reg_wr_data);
    else passed++;
    tick(1'b1, 8'h34);
    checks++;
    if ({reg_wr_en, reg_addr, reg_wr_data, alu_en} !== {1'b1, 4'h1, 8'h34, 1'b0})
      $display("FAIL alu_wr_b: got en=%b addr=%h data=%h alu=%b want en=1 addr=1 data=34 alu=0",
               reg_wr_en, reg_addr, reg_wr_data, alu_en);
    else passed++;
    tick(1'b1, 8'h01);
    checks++;
    if ({alu_en, alu_fun, reg_wr_en} !== {1'b1, 4'h1, 1'b0})
      $display("FAIL alu_start: got alu=%b fun=%h wr=%b want alu=1 fun=1 wr=0", alu_en, alu_fun, reg_wr_en);
    else passed++;
    tick(1'b0, 8'h00);
    checks++;
    if ({wr_cnt, alu_cnt, busy} !== {32'd2, 32'd1, 1'b0})
      $display("FAIL alu_counts: got wr=%0d alu=%0d busy=%b want 2/1/0", wr_cnt, alu_cnt, busy);
    else passed++;
  endtask

  task automatic test_err_nop_reset();
    clr();
    tick(1'b1, 8'h7E);
    checks++;
    if ({frame_err, busy} !== 2'b10) $display("FAIL unknown_cmd: got err=%b busy=%b want 1/0", frame_err, busy);
    else passed++;
    tick(1'b1, 8'hDD);
    checks++;
    if (frame_err !== 1'b0) $display("FAIL err_one_cycle: got %b want 0", frame_err); else passed++;
    tick(1'b1, 8'h03);
    checks++;
    if ({alu_en, alu_fun} !== {1'b1, 4'h3}) $display("FAIL nop_start: got alu=%b fun=%h want 1/3", alu_en, alu_fun);
    else passed++;
    clr();
    tick(1'b1, 8'hAA);
    RST = 1'b1;
    tick(1'b0, 8'h00);
    RST = 1'b0;
    checks++;
    if ({busy, reg_addr, alu_fun} !== 9'd0)
      $display("FAIL mid_reset: got busy=%b addr=%h fun=%h want 0/0/0", busy, reg_addr, alu_fun);
    else passed++;
    // After the reset the former payload lands in IDLE and reads as unknown commands.
    tick(1'b1, 8'h05);
    tick(1'b1, 8'h3C);
    tick(1'b0, 8'h00);
    checks++;
    if ({wr_cnt, err_cnt} !== {32'd0, 32'd2})
      $display("FAIL mid_reset_counts: got wr=%0d err=%0d want 0/2", wr_cnt, err_cnt);
    else passed++;
  endtask

  task automatic test_back_to_back();
    clr();
    tick(1'b1, 8'hAA);
    tick(1'b1, 8'hAA);
    tick(1'b1, 8'hAA);
    checks++;
    if ({reg_wr_en, reg_addr, reg_wr_data} !== {1'b1, 4'hA, 8'hAA})
      $display("FAIL b2b_payload: got en=%b addr=%h data=%h want 1/a/aa", reg_wr_en, reg_addr, reg_wr_data);
    else passed++;
    tick(1'b1, 8'hBB);
    tick(1'b1, 8'h07);
    checks++;
    if ({reg_rd_en, reg_addr} !== {1'b1, 4'h7}) $display("FAIL b2b_next_frame: got en=%b addr=%h want 1/7", reg_rd_en, reg_addr);
    else passed++;
    tick(1'b0, 8'h00);
    checks++;
    if ({wr_cnt, rd_cnt, err_cnt} !== {32'd1, 32'd1, 32'd0})
      $display("FAIL b2b_counts: got wr=%0d rd=%0d err=%0d want 1/1/0", wr_cnt, rd_cnt, err_cnt);
    else passed++;
  endtask

  task automatic test_idle_ignore();
    clr();
    tick(1'b1, 8'hAA);
    for (int i = 0; i < 40; i++) tick(1'b0, 8'hBB);
    checks++;
    if ({busy, err_cnt} !== {1'b1, 32'd0})
      $display("FAIL idle_ignore: got busy=%b err=%0d want 1/0", busy, err_cnt);
    else passed++;
    tick(1'b1, 8'h02);
    tick(1'b1, 8'h55);
    checks++;
    if ({reg_wr_en, reg_addr, reg_wr_data} !== {1'b1, 4'h2, 8'h55})
      $display("FAIL idle_resume: got en=%b addr=%h data=%h want 1/2/55", reg_wr_en, reg_addr, reg_wr_data);
    else passed++;
  endtask

`ifdef CMD_FRAME_TIMEOUT_EN
  task automatic test_timeout();
    clr();
    tick(1'b1, 8'hAA);
    tick(1'b1, 8'h05);
    for (int i = 0; i < 15; i++) tick(1'b0, 8'h00);
    checks++;
    if ({busy, err_cnt} !== {1'b1, 32'd0}) $display("FAIL to_early: got busy=%b err=%0d want 1/0", busy, err_cnt);
    else passed++;
    tick(1'b0, 8'h00);
    checks++;
    if ({frame_err, busy, wr_cnt} !== {1'b1, 1'b0, 32'd0})
      $display("FAIL to_abort: got err=%b busy=%b wr=%0d want 1/0/0", frame_err, busy, wr_cnt);
    else passed++;
    tick(1'b1, 8'hAA);
    tick(1'b1, 8'h05);
    tick(1'b1, 8'h3C);
    checks++;
    if ({reg_wr_en, reg_addr, reg_wr_data} !== {1'b1, 4'h5, 8'h3C})
      $display("FAIL to_recover: got en=%b addr=%h data=%h want 1/5/3c", reg_wr_en, reg_addr, reg_wr_data);
    else passed++;
  endtask
`endif

  initial begin
    clr();
    @(negedge CLK);
    test_reset();
    test_write();
    test_read();
    test_alu_op();
    test_err_nop_reset();
    test_back_to_back();
`ifdef CMD_FRAME_TIMEOUT_EN
    test_timeout();
`else
    test_idle_ignore();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
